// File: rtl/permuter_block_arb.sv
// 2x2 permuter element for the deflection-router network. It picks straight or swap routing
// from flit age and desired port, registers the pair once, and counts deflected flits.
module permuter_block_arb #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned AGE_LSB = 48,
  parameter int unsigned AGE_W   = 8,
  parameter int unsigned DIR_BIT = 63,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_flit0,
  input  logic [WIDTH-1:0] in_flit1,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic [1:0]       mode,
  input  logic             stall,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out_flit0,
  output logic [WIDTH-1:0] out_flit1,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_swap,
  output logic [CNT_W-1:0] defl_cnt
);

  logic [AGE_W-1:0] age0, age1;
  logic             want0, want1;
  logic             winner;
  logic             swapSel;
  logic             deflect;
  logic             rrToggle;
  logic             rrPtrQ;
  logic [WIDTH-1:0] flit0Sel, flit1Sel;
  logic             valid0Sel, valid1Sel;
  logic             cntSat;

  assign age0  = in_flit0[AGE_LSB +: AGE_W];
  assign age1  = in_flit1[AGE_LSB +: AGE_W];
  assign want0 = in_flit0[DIR_BIT];
  assign want1 = in_flit1[DIR_BIT];

  always_comb begin
    winner   = 1'b0;
    swapSel  = 1'b0;
    deflect  = 1'b0;
    rrToggle = 1'b0;
    unique case (mode)
      2'b00: begin
        unique case ({in_valid1, in_valid0})
          2'b01:   swapSel = want0;
          2'b10:   swapSel = ~want1;
          2'b11: begin
            // Older flit wins; ties go to the round-robin pointer.
            if (age0 > age1)      winner = 1'b0;
            else if (age1 > age0) winner = 1'b1;
            else                  winner = rrPtrQ;
            swapSel  = winner ? ~want1 : want0;
            deflect  = (want0 == want1);
            rrToggle = (age0 == age1);
          end
          default: swapSel = 1'b0;
        endcase
      end
      2'b10:   swapSel = 1'b1;
      default: swapSel = 1'b0;
    endcase
  end

  always_comb begin
    valid0Sel = swapSel ? in_valid1 : in_valid0;
    valid1Sel = swapSel ? in_valid0 : in_valid1;
    flit0Sel  = '0;
    flit1Sel  = '0;
    if (valid0Sel) flit0Sel = swapSel ? in_flit1 : in_flit0;
    if (valid1Sel) flit1Sel = swapSel ? in_flit0 : in_flit1;
  end

  assign cntSat = &defl_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_flit0  <= '0;
      out_flit1  <= '0;
      out_valid0 <= 1'b0;
      out_valid1 <= 1'b0;
      out_swap   <= 1'b0;
      rrPtrQ     <= 1'b0;
      defl_cnt   <= '0;
    end else begin
      if (!stall) begin
        out_flit0  <= flit0Sel;
        out_flit1  <= flit1Sel;
        out_valid0 <= valid0Sel;
        out_valid1 <= valid1Sel;
        out_swap   <= swapSel;
        rrPtrQ     <= rrPtrQ ^ rrToggle;
      end
      // Clear beats a same-cycle increment and still acts while stalled.
      if (clr_cnt) begin
        defl_cnt <= '0;
      end else if (!stall && deflect && !cntSat) begin
        defl_cnt <= defl_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_permuter_block_arb.sv
// Directed bench for permuter_block_arb: a reference model pushes expected register state per
// cycle into a queue, which is popped and compared just after each clock edge.
module tb_permuter_block_arb;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned AGE_LSB = 48;
  localparam int unsigned AGE_W   = 8;
  localparam int unsigned DIR_BIT = 63;
  localparam int unsigned CNT_W   = 2;
  localparam logic [CNT_W-1:0] CntMax = '1;

  if (AGE_LSB + AGE_W > WIDTH) begin : gen_bad_age
    $error("illegal AGE_LSB/AGE_W for WIDTH");
  end
  if (DIR_BIT >= WIDTH) begin : gen_bad_dir
    $error("illegal DIR_BIT for WIDTH");
  end

  typedef struct {
    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] f1;
    logic             v0;
    logic             v1;
    logic             sw;
    logic [CNT_W-1:0] cnt;
    logic             rr;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_flit0, in_flit1;
  logic             in_valid0, in_valid1;
  logic [1:0]       mode;
  logic             stall, clr_cnt;
  logic [WIDTH-1:0] out_flit0, out_flit1;
  logic             out_valid0, out_valid1, out_swap;
  logic [CNT_W-1:0] defl_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t m;

  permuter_block_arb #(
    .WIDTH(WIDTH), .AGE_LSB(AGE_LSB), .AGE_W(AGE_W), .DIR_BIT(DIR_BIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_flit0(in_flit0), .in_flit1(in_flit1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .mode(mode), .stall(stall), .clr_cnt(clr_cnt),
    .out_flit0(out_flit0), .out_flit1(out_flit1),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_swap(out_swap), .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mk(input logic dir, input logic [AGE_W-1:0] age);
    logic [WIDTH-1:0] f;
    f = {$urandom, $urandom};
    f[AGE_LSB +: AGE_W] = age;
    f[DIR_BIT] = dir;
    return f;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: advance expected state by one clock using the current inputs.
  task automatic step();
    exp_t n;
    logic [WIDTH-1:0] fl [2];
    logic             vl [2];
    logic             sw, win, defl, tie;
    n = m;
    fl[0] = in_flit0; fl[1] = in_flit1;
    vl[0] = in_valid0; vl[1] = in_valid1;
    sw = 1'b0; defl = 1'b0; tie = 1'b0; win = 1'b0;
    if (mode == 2'b10) sw = 1'b1;
    else if (mode == 2'b00 && (in_valid0 || in_valid1)) begin
      if (!in_valid1) win = 1'b0;
      else if (!in_valid0) win = 1'b1;
      else begin
        tie  = (in_flit0[AGE_LSB +: AGE_W] == in_flit1[AGE_LSB +: AGE_W]);
        win  = tie ? m.rr : (in_flit1[AGE_LSB +: AGE_W] > in_flit0[AGE_LSB +: AGE_W]);
        defl = (in_flit0[DIR_BIT] == in_flit1[DIR_BIT]);
      end
      sw = fl[win][DIR_BIT] ^ win;
    end
    if (reset) begin
      n = '{f0: '0, f1: '0, v0: 1'b0, v1: 1'b0, sw: 1'b0, cnt: '0, rr: 1'b0};
    end else begin
      if (!stall) begin
        n.sw = sw;
        n.v0 = vl[sw];
        n.v1 = vl[!sw];
        n.f0 = vl[sw] ? fl[sw] : '0;
        n.f1 = vl[!sw] ? fl[!sw] : '0;
        if (tie) n.rr = !m.rr;
      end
      if (clr_cnt) n.cnt = '0;
      else if (!stall && defl && m.cnt != CntMax) n.cnt = m.cnt + 1'b1;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e = sb.pop_front();
      check("out_flit0", out_flit0, e.f0);
      check("out_flit1", out_flit1, e.f1);
      check("out_valid0", {63'd0, out_valid0}, {63'd0, e.v0});
      check("out_valid1", {63'd0, out_valid1}, {63'd0, e.v1});
      check("out_swap", {63'd0, out_swap}, {63'd0, e.sw});
      check("defl_cnt", {62'd0, defl_cnt}, {62'd0, e.cnt});
      check("rr_ptr", {63'd0, dut.rrPtrQ}, {63'd0, e.rr});
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] f0, input logic v0,
                       input logic [WIDTH-1:0] f1, input logic v1, input logic [1:0] md);
    in_flit0 = f0; in_valid0 = v0; in_flit1 = f1; in_valid1 = v1; mode = md;
  endtask

  initial begin
    m = '{f0: '0, f1: '0, v0: 1'b0, v1: 1'b0, sw: 1'b0, cnt: '0, rr: 1'b0};
    reset = 1'b1; stall = 1'b0; clr_cnt = 1'b0;
    drive(mk(1'b1, 8'd7), 1'b1, mk(1'b0, 8'd2), 1'b1, 2'b00);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Single valid flit heading to port 1.
    drive(mk(1'b1, 8'd5), 1'b1, mk(1'b0, 8'd0), 1'b0, 2'b00);
    step();
    // Older in1 wins port 0; in0 deflected to port 1.
    drive(mk(1'b0, 8'd3), 1'b1, mk(1'b0, 8'd9), 1'b1, 2'b00);
    step();
    // Equal ages: winner alternates through the round-robin pointer.
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 8'd4), 1'b1, mk(1'b1, 8'd4), 1'b1, 2'b00);
      step();
    end
    // Only in1 valid, wants port 0.
    drive(mk(1'b1, 8'd1), 1'b0, mk(1'b0, 8'd6), 1'b1, 2'b00);
    step();

    // Stall with a tied deflecting pair held at the inputs.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    drive(mk(1'b0, 8'd8), 1'b1, mk(1'b0, 8'd8), 1'b1, 2'b00);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stall = 1'b0;
    step();
    // Clear while stalled.
    stall = 1'b1; clr_cnt = 1'b1;
    step();
    stall = 1'b0; clr_cnt = 1'b0;

    // Counter saturation at 3.
    for (int i = 0; i < 5; i++) begin
      drive(mk(1'b1, 8'(10 + i)), 1'b1, mk(1'b1, 8'd12), 1'b1, 2'b00);
      step();
    end
    clr_cnt = 1'b1;
    drive(mk(1'b0, 8'd20), 1'b1, mk(1'b0, 8'd1), 1'b1, 2'b00);
    step();
    clr_cnt = 1'b0;
    drive(mk(1'b0, 8'd20), 1'b1, mk(1'b0, 8'd1), 1'b1, 2'b00);
    step();

    // Forced modes: no counting, no pointer movement.
    drive(mk(1'b0, 8'd5), 1'b1, mk(1'b0, 8'd5), 1'b1, 2'b10);
    step();
    drive(mk(1'b1, 8'd5), 1'b1, mk(1'b1, 8'd5), 1'b1, 2'b11);
    step();
    drive(mk(1'b1, 8'd5), 1'b0, mk(1'b0, 8'd5), 1'b1, 2'b01);
    step();
    drive(mk(1'b0, 8'd2), 1'b1, mk(1'b0, 8'd2), 1'b1, 2'b10);
    step();

    // Reset with live traffic discards the registered pair.
    reset = 1'b1;
    drive(mk(1'b1, 8'd9), 1'b1, mk(1'b1, 8'd3), 1'b1, 2'b00);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
